fft_sram_responder: RTL and testbench
=====================================

Name: fft_sram_responder

Overview:
- Memory-side responder for the fft_top SRAM interface: services fft_top's two read ports and two write ports against a 256 x 128 scratchpad.
- Provides a host load/unload port so samples can be written before a run and results read back after it.
- Contains an ownership state machine that arbitrates between the host and the FFT engine; sits between fft_top and the chip-level host bus.

Parameters:
DEPTH, 256, words in scratchpad (address width = log2(DEPTH) = 8)
WIDTH, 128, bits per word (4 x 32-bit complex chunks)
CNT_W, 16, width of write-beat counter

Ports:
clk  in  1  clock
rstn  in  1  synchronous active-low reset
i_start  in  1  host request to hand memory to FFT engine (pulse)
i_fft_done  in  1  from fft_top o_fft_done
o_working  out  1  drives fft_top i_working; high while FFT owns memory
i_raddress1  in  8  FFT read address, port 1
i_raddress2  in  8  FFT read address, port 2
o_rdata1  out  128  read data, port 1
o_rdata2  out  128  read data, port 2
i_sram_read_register  in  1  read-data register enable from fft_top
i_waddress1  in  8  FFT write address, port 1
i_waddress2  in  8  FFT write address, port 2
i_wdata1  in  128  FFT write data, port 1
i_wdata2  in  128  FFT write data, port 2
i_global_write_enable  in  1  writes both FFT ports this cycle
i_host_valid  in  1  host request valid
i_host_we  in  1  1 = write, 0 = read
i_host_addr  in  8  host address
i_host_wdata  in  128  host write data
o_host_ready  out  1  host request accepted this cycle
o_host_rvalid  out  1  host read data valid
o_host_rdata  out  128  host read data
o_done_pulse  out  1  one-cycle pulse when the FFT run completes
o_collision  out  1  sticky: both FFT write ports hit the same address
o_write_count  out  CNT_W  FFT write beats in current/last run

Behaviour:
- Reset (rstn=0 at posedge): state=S_HOST; o_working, o_host_ready, o_host_rvalid, o_done_pulse, o_collision = 0; o_rdata1/2, o_host_rdata = 0; o_write_count = 0. Memory contents are not cleared.
- States:
  - S_HOST: o_host_ready = i_host_valid (combinational). i_start=1 -> S_FFT next cycle. If i_start and i_host_valid coincide, the host access completes this cycle, then the state moves to S_FFT.
  - S_FFT: o_working=1 (registered, asserted the cycle after entry); o_host_ready=0. Entry clears o_write_count and o_collision. i_fft_done=1 -> S_DONE.
  - S_DONE: o_working=0; o_done_pulse=1 for exactly this cycle; S_HOST next.
- FFT reads:
  - 1-cycle latency. On a posedge with i_sram_read_register=1 and state S_FFT, o_rdataN <= mem[i_raddressN].
  - Otherwise o_rdataN holds its value.
  - Read-before-write: a same-cycle read of an address being written returns the old data.
- FFT writes:
  - Accepted only in S_FFT with i_global_write_enable=1. Writes mem[i_waddress1]=i_wdata1 and mem[i_waddress2]=i_wdata2; ignored in any other state.
  - If i_waddress1==i_waddress2, port 2 data wins and o_collision sets (sticky until the next S_FFT entry).
  - o_write_count increments by 1 per enabled beat; saturates at all-ones.
- Host access (S_HOST only):
  - Write: mem[i_host_addr]=i_host_wdata at the accepting edge.
  - Read: o_host_rdata=mem[i_host_addr] and o_host_rvalid=1 in the cycle after acceptance. o_host_rvalid deasserts otherwise; o_host_rdata holds.
  - Back-to-back reads produce one rvalid per accepted request.
- i_fft_done outside S_FFT is ignored. i_start outside S_HOST is ignored.
- Reset mid-run: returns to S_HOST; o_working drops at the next edge; memory retains any partial results.

Test Plan:
- Host writes 0x...0001 to addr 5, then reads addr 5 -> o_host_rvalid=1 one cycle after accept, o_host_rdata=128'h1.
- i_start with FFT raddress1=5, raddress2=6 and read_register=1 -> o_rdata1=mem[5], o_rdata2=mem[6] one cycle later. With read_register=0, o_rdata holds its previous value.
- Same cycle: write addr 7 = A and read addr 7 (old value B) -> o_rdata1=B; next read of addr 7 -> A.
- Write enable with waddress1=waddress2=9, wdata1=X, wdata2=Y -> mem[9]=Y, o_collision=1. o_collision clears on the next i_start.
- 128 write beats then i_fft_done -> o_write_count=128, o_done_pulse high for exactly 1 cycle, o_working=0, host ready again.
- Host request while in S_FFT -> o_host_ready=0 and memory unchanged. rstn=0 mid-run -> S_HOST, all outputs at reset values.

Source files
------------

// File: rtl/fft_sram_responder.sv
// fft_sram_responder: scratchpad serving fft_top's SRAM ports, with host load/unload and ownership FSM
module fft_sram_responder #(
  parameter int DEPTH = 256,
  parameter int WIDTH = 128,
  parameter int CNT_W = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_start,
  input  logic             i_fft_done,
  output logic             o_working,
  input  logic [AW-1:0]    i_raddress1,
  input  logic [AW-1:0]    i_raddress2,
  output logic [WIDTH-1:0] o_rdata1,
  output logic [WIDTH-1:0] o_rdata2,
  input  logic             i_sram_read_register,
  input  logic [AW-1:0]    i_waddress1,
  input  logic [AW-1:0]    i_waddress2,
  input  logic [WIDTH-1:0] i_wdata1,
  input  logic [WIDTH-1:0] i_wdata2,
  input  logic             i_global_write_enable,
  input  logic             i_host_valid,
  input  logic             i_host_we,
  input  logic [AW-1:0]    i_host_addr,
  input  logic [WIDTH-1:0] i_host_wdata,
  output logic             o_host_ready,
  output logic             o_host_rvalid,
  output logic [WIDTH-1:0] o_host_rdata,
  output logic             o_done_pulse,
  output logic             o_collision,
  output logic [CNT_W-1:0] o_write_count
);
  typedef enum logic [1:0] {S_HOST, S_FFT, S_DONE} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] mem [DEPTH];
  logic fft_we, fft_rd, entry;
  assign o_host_ready = (state == S_HOST) && i_host_valid;
  assign fft_we = (state == S_FFT) && i_global_write_enable;
  assign fft_rd = (state == S_FFT) && i_sram_read_register;
  assign entry = (state == S_HOST) && i_start;
  // ownership next-state: host -> fft on start, fft -> done on completion, done -> host
  always_comb begin
    state_n = state;
    case (state)
      S_HOST:  if (i_start) state_n = S_FFT;
      S_FFT:   if (i_fft_done) state_n = S_DONE;
      default: state_n = S_HOST;
    endcase
  end
  // state register plus registered ownership/done flags decoded from the next state
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= S_HOST;
      o_working <= 1'b0;
      o_done_pulse <= 1'b0;
    end else begin
      state <= state_n;
      o_working <= state_n == S_FFT;
      o_done_pulse <= state_n == S_DONE;
    end
  end
  // scratchpad writes; port 2 is written last so it wins on an address collision
  always_ff @(posedge clk) begin
    if (o_host_ready && i_host_we) mem[i_host_addr] <= i_host_wdata;
    if (fft_we) begin
      mem[i_waddress1] <= i_wdata1;
      mem[i_waddress2] <= i_wdata2;
    end
  end
  // read registers see pre-write contents, giving read-before-write on same-address access
  always_ff @(posedge clk) begin
    if (!rstn) begin
      o_rdata1 <= '0;
      o_rdata2 <= '0;
      o_host_rdata <= '0;
      o_host_rvalid <= 1'b0;
    end else begin
      if (fft_rd) begin
        o_rdata1 <= mem[i_raddress1];
        o_rdata2 <= mem[i_raddress2];
      end
      o_host_rvalid <= o_host_ready && !i_host_we;
      if (o_host_ready && !i_host_we) o_host_rdata <= mem[i_host_addr];
    end
  end
  // run statistics: cleared on entry to the FFT phase, collision is sticky for the run
  always_ff @(posedge clk) begin
    if (!rstn || entry) begin
      o_write_count <= '0;
      o_collision <= 1'b0;
    end else if (fft_we) begin
      o_write_count <= o_write_count + CNT_W'(o_write_count != '1);
      if (i_waddress1 == i_waddress2) o_collision <= 1'b1;
    end
  end
endmodule

// File: tb/tb_fft_sram_responder.sv
// tb_fft_sram_responder: directed self-checking bench for fft_sram_responder
module tb_fft_sram_responder;
  logic clk = 0, rstn = 0;
  logic i_start = 0, i_fft_done = 0, o_working;
  logic [7:0] i_raddress1 = 0, i_raddress2 = 0, i_waddress1 = 0, i_waddress2 = 0, i_host_addr = 0;
  logic [127:0] o_rdata1, o_rdata2, i_wdata1 = 0, i_wdata2 = 0, i_host_wdata = 0, o_host_rdata;
  logic i_sram_read_register = 0, i_global_write_enable = 0;
  logic i_host_valid = 0, i_host_we = 0, o_host_ready, o_host_rvalid, o_done_pulse, o_collision;
  logic [15:0] o_write_count;
  int n_checks = 0, n_fail = 0;

  localparam logic [127:0] VB = 128'hBBBB_0000_0000_0000_0000_0000_0000_BBBB;
  localparam logic [127:0] VA = 128'hAAAA_1111_2222_3333_4444_5555_6666_7777;
  localparam logic [127:0] VX = 128'h1234;
  localparam logic [127:0] VY = 128'h5678_0000_0000_0000_0000_0000_0000_9ABC;
  localparam logic [127:0] VZ = 128'hCAFE_F00D;

  fft_sram_responder dut (
    .clk(clk), .rstn(rstn), .i_start(i_start), .i_fft_done(i_fft_done), .o_working(o_working),
    .i_raddress1(i_raddress1), .i_raddress2(i_raddress2), .o_rdata1(o_rdata1), .o_rdata2(o_rdata2),
    .i_sram_read_register(i_sram_read_register), .i_waddress1(i_waddress1), .i_waddress2(i_waddress2),
    .i_wdata1(i_wdata1), .i_wdata2(i_wdata2), .i_global_write_enable(i_global_write_enable),
    .i_host_valid(i_host_valid), .i_host_we(i_host_we), .i_host_addr(i_host_addr),
    .i_host_wdata(i_host_wdata), .o_host_ready(o_host_ready), .o_host_rvalid(o_host_rvalid),
    .o_host_rdata(o_host_rdata), .o_done_pulse(o_done_pulse), .o_collision(o_collision),
    .o_write_count(o_write_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic host_write(input logic [7:0] a, input logic [127:0] d);
    i_host_valid = 1; i_host_we = 1; i_host_addr = a; i_host_wdata = d;
    tick();
    i_host_valid = 0; i_host_we = 0;
  endtask

  task automatic test_reset();
    rstn = 0;
    tick(); tick();
    n_checks++; if (o_working !== 1'b0) begin n_fail++; $display("FAIL reset_working got %b exp 0", o_working); end
    n_checks++; if (o_host_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b exp 0", o_host_ready); end
    n_checks++; if (o_host_rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid got %b exp 0", o_host_rvalid); end
    n_checks++; if (o_done_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b exp 0", o_done_pulse); end
    n_checks++; if (o_collision !== 1'b0) begin n_fail++; $display("FAIL reset_coll got %b exp 0", o_collision); end
    n_checks++; if (o_write_count !== 16'd0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", o_write_count); end
    n_checks++; if ({o_rdata1, o_rdata2, o_host_rdata} !== 384'd0) begin n_fail++; $display("FAIL reset_data got %h %h %h exp 0", o_rdata1, o_rdata2, o_host_rdata); end
    rstn = 1;
    tick();
  endtask

  task automatic test_host();
    i_host_valid = 1; i_host_we = 1; i_host_addr = 5; i_host_wdata = 128'h1;
    #1;
    n_checks++; if (o_host_ready !== 1'b1) begin n_fail++; $display("FAIL host_ready got %b exp 1", o_host_ready); end
    tick();
    i_host_valid = 0; i_host_we = 0;
    n_checks++; if (o_host_rvalid !== 1'b0) begin n_fail++; $display("FAIL host_write_rvalid got %b exp 0", o_host_rvalid); end
    host_write(6, 128'h66);
    host_write(7, VB);
    i_host_fft_done_check();
    i_host_valid = 1; i_host_addr = 5;
    tick();
    i_host_valid = 0;
    n_checks++; if (o_host_rvalid !== 1'b1) begin n_fail++; $display("FAIL host_rvalid got %b exp 1", o_host_rvalid); end
    n_checks++; if (o_host_rdata !== 128'h1) begin n_fail++; $display("FAIL host_rdata got %h exp 1", o_host_rdata); end
    tick();
    n_checks++; if (o_host_rvalid !== 1'b0) begin n_fail++; $display("FAIL host_rvalid_drop got %b exp 0", o_host_rvalid); end
    n_checks++; if (o_host_rdata !== 128'h1) begin n_fail++; $display("FAIL host_rdata_hold got %h exp 1", o_host_rdata); end
  endtask

  task automatic i_host_fft_done_check();
    i_fft_done = 1;
    tick();
    i_fft_done = 0;
    n_checks++; if (o_done_pulse !== 1'b0) begin n_fail++; $display("FAIL done_ignored got %b exp 0", o_done_pulse); end
  endtask

  task automatic test_back_to_back();
    i_host_valid = 1; i_host_we = 0; i_host_addr = 6;
    tick();
    n_checks++; if (o_host_rvalid !== 1'b1 || o_host_rdata !== 128'h66) begin n_fail++; $display("FAIL b2b_first got %b %h exp 1 66", o_host_rvalid, o_host_rdata); end
    i_host_addr = 7;
    tick();
    i_host_valid = 0;
    n_checks++; if (o_host_rvalid !== 1'b1 || o_host_rdata !== VB) begin n_fail++; $display("FAIL b2b_second got %b %h exp 1 %h", o_host_rvalid, o_host_rdata, VB); end
    tick();
    n_checks++; if (o_host_rvalid !== 1'b0) begin n_fail++; $display("FAIL b2b_drop got %b exp 0", o_host_rvalid); end
  endtask

  task automatic test_fft_read();
    i_start = 1;
    tick();
    i_start = 0;
    n_checks++; if (o_working !== 1'b1) begin n_fail++; $display("FAIL fft_working got %b exp 1", o_working); end
    i_raddress1 = 5; i_raddress2 = 6; i_sram_read_register = 1;
    tick();
    n_checks++; if (o_rdata1 !== 128'h1 || o_rdata2 !== 128'h66) begin n_fail++; $display("FAIL fft_read got %h %h exp 1 66", o_rdata1, o_rdata2); end
    i_sram_read_register = 0; i_raddress1 = 6; i_raddress2 = 7;
    tick();
    n_checks++; if (o_rdata1 !== 128'h1 || o_rdata2 !== 128'h66) begin n_fail++; $display("FAIL fft_read_hold got %h %h exp 1 66", o_rdata1, o_rdata2); end
  endtask

  task automatic test_read_before_write();
    i_raddress1 = 7; i_sram_read_register = 1;
    i_waddress1 = 7; i_wdata1 = VA; i_waddress2 = 8; i_wdata2 = 128'hC; i_global_write_enable = 1;
    tick();
    i_global_write_enable = 0;
    n_checks++; if (o_rdata1 !== VB) begin n_fail++; $display("FAIL rbw_old got %h exp %h", o_rdata1, VB); end
    tick();
    i_sram_read_register = 0;
    n_checks++; if (o_rdata1 !== VA) begin n_fail++; $display("FAIL rbw_new got %h exp %h", o_rdata1, VA); end
  endtask

  task automatic test_collision();
    n_checks++; if (o_collision !== 1'b0) begin n_fail++; $display("FAIL coll_pre got %b exp 0", o_collision); end
    i_waddress1 = 9; i_waddress2 = 9; i_wdata1 = VX; i_wdata2 = VY; i_global_write_enable = 1;
    tick();
    i_global_write_enable = 0;
    n_checks++; if (o_collision !== 1'b1) begin n_fail++; $display("FAIL coll_set got %b exp 1", o_collision); end
    i_raddress2 = 9; i_sram_read_register = 1;
    tick();
    i_sram_read_register = 0;
    n_checks++; if (o_rdata2 !== VY) begin n_fail++; $display("FAIL coll_data got %h exp %h", o_rdata2, VY); end
  endtask

  task automatic test_host_blocked();
    i_host_valid = 1; i_host_we = 1; i_host_addr = 5; i_host_wdata = 128'hDEAD;
    #1;
    n_checks++; if (o_host_ready !== 1'b0) begin n_fail++; $display("FAIL blocked_ready got %b exp 0", o_host_ready); end
    tick();
    i_host_valid = 0; i_host_we = 0;
    i_raddress1 = 5; i_sram_read_register = 1;
    tick();
    i_sram_read_register = 0;
    n_checks++; if (o_rdata1 !== 128'h1) begin n_fail++; $display("FAIL blocked_mem got %h exp 1", o_rdata1); end
    n_checks++; if (o_write_count !== 16'd2) begin n_fail++; $display("FAIL count_two got %0d exp 2", o_write_count); end
  endtask

  task automatic test_done();
    i_fft_done = 1;
    tick();
    i_fft_done = 0;
    n_checks++; if (o_done_pulse !== 1'b1 || o_working !== 1'b0) begin n_fail++; $display("FAIL done_state got pulse %b working %b exp 1 0", o_done_pulse, o_working); end
    tick();
    n_checks++; if (o_done_pulse !== 1'b0) begin n_fail++; $display("FAIL done_once got %b exp 0", o_done_pulse); end
    n_checks++; if (o_collision !== 1'b1) begin n_fail++; $display("FAIL coll_sticky got %b exp 1", o_collision); end
    i_host_valid = 1; i_host_we = 0; i_host_addr = 9;
    #1;
    n_checks++; if (o_host_ready !== 1'b1) begin n_fail++; $display("FAIL ready_again got %b exp 1", o_host_ready); end
    tick();
    i_host_valid = 0;
    n_checks++; if (o_host_rdata !== VY) begin n_fail++; $display("FAIL unload9 got %h exp %h", o_host_rdata, VY); end
  endtask

  task automatic test_count();
    i_start = 1;
    tick();
    i_start = 0;
    n_checks++; if (o_collision !== 1'b0 || o_write_count !== 16'd0) begin n_fail++; $display("FAIL entry_clear got coll %b count %0d exp 0 0", o_collision, o_write_count); end
    for (int i = 0; i < 128; i++) begin
      i_waddress1 = 8'(i); i_waddress2 = 8'(i + 128);
      i_wdata1 = {96'd0, 32'(i)}; i_wdata2 = {32'(i), 96'd0};
      i_global_write_enable = 1;
      tick();
    end
    i_global_write_enable = 0;
    n_checks++; if (o_write_count !== 16'd128) begin n_fail++; $display("FAIL count128 got %0d exp 128", o_write_count); end
    n_checks++; if (o_collision !== 1'b0) begin n_fail++; $display("FAIL coll_clean got %b exp 0", o_collision); end
    i_fft_done = 1;
    tick();
    i_fft_done = 0;
    n_checks++; if (o_done_pulse !== 1'b1) begin n_fail++; $display("FAIL done128 got %b exp 1", o_done_pulse); end
    tick();
    n_checks++; if (o_done_pulse !== 1'b0 || o_working !== 1'b0) begin n_fail++; $display("FAIL after128 got pulse %b working %b exp 0 0", o_done_pulse, o_working); end
    i_host_valid = 1; i_host_we = 0; i_host_addr = 130;
    tick();
    i_host_valid = 0;
    n_checks++; if (o_host_rdata !== {32'd2, 96'd0}) begin n_fail++; $display("FAIL unload130 got %h exp %h", o_host_rdata, {32'd2, 96'd0}); end
  endtask

  task automatic test_reset_midrun();
    i_start = 1;
    tick();
    i_start = 0;
    i_waddress1 = 20; i_waddress2 = 21; i_wdata1 = VZ; i_wdata2 = VZ; i_global_write_enable = 1;
    i_raddress1 = 5; i_raddress2 = 6; i_sram_read_register = 1;
    tick();
    i_global_write_enable = 0; i_sram_read_register = 0;
    n_checks++; if (o_working !== 1'b1 || o_write_count !== 16'd1) begin n_fail++; $display("FAIL midrun got working %b count %0d exp 1 1", o_working, o_write_count); end
    rstn = 0;
    tick();
    n_checks++; if (o_working !== 1'b0 || o_write_count !== 16'd0 || o_rdata1 !== 128'd0 || o_rdata2 !== 128'd0) begin n_fail++; $display("FAIL midrun_reset got working %b count %0d rd %h %h exp 0 0 0 0", o_working, o_write_count, o_rdata1, o_rdata2); end
    rstn = 1;
    i_host_valid = 1; i_host_we = 0; i_host_addr = 20;
    #1;
    n_checks++; if (o_host_ready !== 1'b1) begin n_fail++; $display("FAIL midrun_ready got %b exp 1", o_host_ready); end
    tick();
    i_host_valid = 0;
    n_checks++; if (o_host_rvalid !== 1'b1 || o_host_rdata !== VZ) begin n_fail++; $display("FAIL midrun_mem got %b %h exp 1 %h", o_host_rvalid, o_host_rdata, VZ); end
  endtask

  initial begin
    test_reset();
    test_host();
    test_back_to_back();
    test_fft_read();
    test_read_before_write();
    test_collision();
    test_host_blocked();
    test_done();
    test_count();
    test_reset_midrun();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
